// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide execute unit. It sits directly after the
// register file and produces the {WriteReg1, WriteReg15} pair for the two-register
// write-back.
//   multiply : result_lo = product low half, result_hi = product high half
//   divide   : result_lo = quotient,         result_hi = remainder
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous, active-low reset
//   start        request, sampled only in IDLE
//   op[1:0]      op[0]: 0=multiply 1=divide; op[1]: signed (SIGNED_MULDIV_EN only)
//   opa, opb     multiplicand/dividend, multiplier/divisor
//   busy         high while iterating
//   done         one-cycle pulse, results valid
//   result_lo    product low half or quotient
//   result_hi    product high half or remainder
//   div_by_zero  qualifies done for a divide with opb==0
//   wr_dst       2'b10 while done, else 2'b00
//
// Build option
//   SIGNED_MULDIV_EN  when defined, op[1]=1 selects two's-complement operation.
//                     When undefined, op[1] is ignored and no sign logic exists.
//
// State table
//   state    | meaning
//   ST_IDLE  | waiting for start; operands are latched on the start edge
//   ST_RUN   | one shift-add / shift-subtract iteration per clock
//   ST_DONE  | iteration finished; results, done and wr_dst register on the next edge
module muldiv_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero,
    output logic [1:0]       wr_dst
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               dz_q, dz_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] fin;
    logic               start_dz;

    assign start_dz = op[0] && (opb == '0);

`ifdef SIGNED_MULDIV_EN
    logic sgn_a, sgn_b;
    logic neg_a_q, neg_a_d;
    logic neg_x_q, neg_x_d;

    assign sgn_a = op[1] & opa[WIDTH-1];
    assign sgn_b = op[1] & opb[WIDTH-1];
    assign mag_a = sgn_a ? ('0 - opa) : opa;
    assign mag_b = sgn_b ? ('0 - opb) : opb;

    always_comb begin
        neg_a_d = neg_a_q;
        neg_x_d = neg_x_q;
        if (state_q == ST_IDLE && start) begin
            neg_a_d = sgn_a;
            neg_x_d = sgn_a ^ sgn_b;
        end
    end

    // Product negates as a whole; quotient follows sign(a)^sign(b) and the
    // remainder follows the dividend. A divide by zero bypasses correction.
    always_comb begin
        fin = acc_q;
        if (!dz_q) begin
            if (!div_q) begin
                if (neg_x_q) fin = '0 - acc_q;
            end else begin
                if (neg_x_q) fin[WIDTH-1:0]       = '0 - acc_q[WIDTH-1:0];
                if (neg_a_q) fin[2*WIDTH-1:WIDTH] = '0 - acc_q[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_a_q <= 1'b0;
            neg_x_q <= 1'b0;
        end else begin
            neg_a_q <= neg_a_d;
            neg_x_q <= neg_x_d;
        end
    end
`else
    logic unused_op1;
    assign unused_op1 = op[1];
    assign mag_a      = opa;
    assign mag_b      = opb;
    assign fin        = acc_q;
`endif

    // Iteration datapaths. acc holds {high, low} for multiply and
    // {remainder, quotient/dividend} for divide.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Partial remainder is always < divisor, so the shifted value fits in
        // WIDTH+1 bits and the borrow bit alone decides restore vs keep.
        div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, b_q};
        div_ge   = ~div_diff[WIDTH];
        div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                    acc_q[WIDTH-2:0], div_ge};
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = start_dz ? ST_DONE : ST_RUN;
            ST_RUN:  if (cnt_q == CW'(WIDTH - 1)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy        = (state_q == ST_RUN);
        done        = done_q;
        wr_dst      = done_q ? 2'b10 : 2'b00;
        result_lo   = res_lo_q;
        result_hi   = res_hi_q;
        div_by_zero = dbz_q;
    end

    // Datapath next values
    always_comb begin
        acc_d    = acc_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        dbz_d    = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    div_d = op[0];
                    dz_d  = start_dz;
                    b_d   = mag_b;
                    acc_d = start_dz ? {opa, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, mag_a};
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CW'(1);
                acc_d = div_q ? div_next : mul_next;
            end
            ST_DONE: begin
                done_d   = 1'b1;
                res_lo_d = fin[WIDTH-1:0];
                res_hi_d = fin[2*WIDTH-1:WIDTH];
                dbz_d    = dz_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            dbz_q    <= dbz_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] opa = '0;
    logic [15:0] opb = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] result_lo, result_hi;
    logic [1:0]  wr_dst;

    int checks = 0;
    int failures = 0;
    logic [15:0] prev_lo = '0;
    logic [15:0] prev_hi = '0;

    muldiv_unit #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
        .div_by_zero(div_by_zero), .wr_dst(wr_dst)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {div_by_zero, hi, lo} from plain arithmetic.
    function automatic logic [32:0] model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        logic   sgn;
        int     sa, sb, q, r;
        longint ua, ub, p;
        logic [31:0] w;
`ifdef SIGNED_MULDIV_EN
        sgn = o[1];
`else
        sgn = 1'b0;
`endif
        sa = $signed(a);
        sb = $signed(b);
        ua = longint'(a);
        ub = longint'(b);
        if (o[0]) begin
            if (b == 16'h0) return {1'b1, a, 16'hFFFF};
            if (sgn) begin q = sa / sb; r = sa % sb; end
            else     begin q = int'(ua / ub); r = int'(ua % ub); end
            return {1'b0, r[15:0], q[15:0]};
        end
        if (sgn) w = 32'(sa * sb);
        else begin p = ua * ub; w = p[31:0]; end
        return {1'b0, w};
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [32:0] exp;
        int done_k, busy_n, exp_lat, exp_busy;
        bit wr_bad;
        exp      = model(o, a, b);
        exp_lat  = exp[32] ? 1 : 17;
        exp_busy = exp[32] ? 0 : 16;
        done_k = -1; busy_n = 0; wr_bad = 0;
        @(negedge clk); start = 1'b1; op = o; opa = a; opb = b;
        @(negedge clk); start = 1'b0;
        op = 2'($urandom_range(0, 3)); opa = 16'($urandom); opb = 16'($urandom);
        check({tag, ":hold_lo"}, {16'h0, result_lo}, {16'h0, prev_lo});
        check({tag, ":hold_hi"}, {16'h0, result_hi}, {16'h0, prev_hi});
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (busy) busy_n++;
            if (done) begin done_k = k; break; end
            if (wr_dst !== 2'b00) wr_bad = 1;
        end
        check({tag, ":latency"}, done_k, exp_lat);
        check({tag, ":busy_cycles"}, busy_n, exp_busy);
        check({tag, ":wr_idle"}, {31'h0, wr_bad}, 32'h0);
        check({tag, ":wr_dst"}, {30'h0, wr_dst}, 32'h2);
        check({tag, ":lo"}, {16'h0, result_lo}, {16'h0, exp[15:0]});
        check({tag, ":hi"}, {16'h0, result_hi}, {16'h0, exp[31:16]});
        check({tag, ":dbz"}, {31'h0, div_by_zero}, {31'h0, exp[32]});
        @(negedge clk);
        check({tag, ":done_1cyc"}, {30'h0, wr_dst, done}, 32'h0);
        prev_lo = exp[15:0];
        prev_hi = exp[31:16];
    endtask

    initial begin
        logic [32:0] exp;
        logic [15:0] got_lo, got_hi;
        logic        got_dbz;
        int          pulses;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset:busy_done", {30'h0, busy, done}, 32'h0);
        check("reset:results", {result_hi, result_lo}, 32'h0);
        check("reset:dbz_wr", {29'h0, div_by_zero, wr_dst}, 32'h0);
        rst = 1'b1;

        // Directed cases
        run_op(2'b00, 16'h0003, 16'h0005, "mul3x5");
        run_op(2'b00, 16'hFFFF, 16'hFFFF, "mulmax");
        run_op(2'b01, 16'd100, 16'd7, "div100_7");
        run_op(2'b01, 16'h1234, 16'h0000, "div0");
        run_op(2'b11, 16'hFFF9, 16'h0002, "sdiv_m7_2");
        run_op(2'b10, 16'hFFFA, 16'h0007, "smul_m6_7");
        run_op(2'b11, 16'h8000, 16'hFFFF, "sdiv_wrap");
        run_op(2'b11, 16'h8001, 16'h0000, "sdiv0");
        run_op(2'b01, 16'h0005, 16'h0009, "div_small");

        // start during RUN is ignored
        exp = model(2'b00, 16'h1234, 16'h0056);
        @(negedge clk); start = 1'b1; op = 2'b00; opa = 16'h1234; opb = 16'h0056;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b01; opa = 16'h4321; opb = 16'h0000;
        @(negedge clk); start = 1'b0;
        pulses = 0; got_lo = '0; got_hi = '0; got_dbz = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) begin pulses++; got_lo = result_lo; got_hi = result_hi; got_dbz = div_by_zero; end
        end
        check("ignore:pulses", pulses, 1);
        check("ignore:result", {got_hi, got_lo}, exp[31:0]);
        check("ignore:dbz", {31'h0, got_dbz}, 32'h0);
        prev_lo = exp[15:0];
        prev_hi = exp[31:16];

        // Reset mid-operation
        @(negedge clk); start = 1'b1; op = 2'b00; opa = 16'h00FF; opb = 16'h0101;
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst:busy_done", {30'h0, busy, done}, 32'h0);
        check("midrst:results", {result_hi, result_lo}, 32'h0);
        check("midrst:dbz_wr", {29'h0, div_by_zero, wr_dst}, 32'h0);
        @(negedge clk); rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("midrst:no_done", pulses, 0);
        prev_lo = '0;
        prev_hi = '0;
        run_op(2'b00, 16'h00FF, 16'h0101, "after_rst");

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [15:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(1, 20));
            run_op(ro, ra, rb, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 16-bit multiply/divide execute unit directly downstream of the register file.
- Consumes the two read-port operands; produces the {WriteReg1, WriteReg15} pair for the two-register write (WriteDst=2'b10):
  - multiply: low half to Rd, high half to R15.
  - divide: quotient to Rd, remainder to R15.
- The datapath write-back mux gates the write using done.

Parameters:
- WIDTH, 16, operand and result-half width. Iteration count equals WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  op[0]: 0=multiply, 1=divide. op[1]: 1=signed (only with SIGNED_MULDIV_EN).
- opa  input  WIDTH  multiplicand or dividend (register-file Data1).
- opb  input  WIDTH  multiplier or divisor (register-file Data2).
- busy  output  1  high while an operation is in progress (RUN).
- done  output  1  one-cycle pulse; results valid.
- result_lo  output  WIDTH  product[WIDTH-1:0] or quotient; to WriteReg1.
- result_hi  output  WIDTH  product[2*WIDTH-1:WIDTH] or remainder; to WriteReg15.
- div_by_zero  output  1  set with done when a divide had opb==0.
- wr_dst  output  2  2'b10 while done=1, otherwise 2'b00. Write-back is qualified by done.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, result_lo=0, result_hi=0, div_by_zero=0, wr_dst=2'b00, iteration counter=0.
  - Reset mid-operation discards the operation; no done pulse follows.
- States are IDLE, RUN and DONE.
- IDLE:
  - On the edge where start=1, latch opa, opb and op; clear the counter; go to RUN; busy=1 from that edge.
  - Divide with opb==0 goes directly to DONE instead of RUN.
- RUN:
  - One iteration per clock; counter increments.
  - After WIDTH iterations go to DONE; busy=0 on that same edge.
- DONE:
  - done=1 and wr_dst=2'b10 for exactly one cycle, then return to IDLE.
  - start is not accepted in DONE.
- Latency: with start sampled at edge E0, done is high in the cycle after edge E(WIDTH+1), i.e. after E17 for WIDTH=16.
  - Back-to-back start is accepted at the earliest on edge E(WIDTH+2).
- start while busy or in DONE is ignored: no queueing, latched operands unchanged.
- Result hold: result_lo, result_hi and div_by_zero update only on entry to DONE. They hold until the next DONE or reset; they are not cleared at start.
- Multiply (unsigned): shift-add over a 2*WIDTH accumulator; exact 32-bit product, no overflow.
- Divide (unsigned): restoring shift-subtract; quotient and remainder satisfy opa = q*opb + r, with r < opb.
- Divide by zero: result_lo=all ones (0xFFFF), result_hi=opa, div_by_zero=1, done in the cycle after edge E1.
  - div_by_zero is 0 for every other completion.
- Operand inputs may change freely after the start edge; only the latched copies are used.

Optional Feature:
- Macro: SIGNED_MULDIV_EN.
- Defined, op[1]=1 selects two's-complement operation:
  - Operands are converted to magnitudes at the start edge, then the unsigned iteration runs.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; truncation is toward zero.
  - Remainder takes the sign of the dividend.
  - 0x8000 / 0xFFFF gives quotient 0x8000 and remainder 0 (wraps, no flag).
  - Signed divide by zero: same outputs as the unsigned case.
  - Latency is identical to unsigned.
- Undefined: op[1] is ignored; all operations are unsigned; no sign-correction logic is present.

Test Plan:
- Unsigned multiply: start, op=00, opa=0x0003, opb=0x0005 -> busy for 16 cycles; done after E17; lo=0x000F, hi=0x0000, wr_dst=2'b10 for one cycle only.
- Unsigned multiply: opa=0xFFFF, opb=0xFFFF -> lo=0x0001, hi=0xFFFE. Then unsigned divide: op=01, opa=100, opb=7 -> lo=0x000E, hi=0x0002, div_by_zero=0.
- Divide by zero: op=01, opa=0x1234, opb=0 -> done after E1; lo=0xFFFF, hi=0x1234, div_by_zero=1; busy never asserted.
- Start during RUN with different operands -> ignored; original result delivered; exactly one done pulse.
- rst pulsed low at iteration 8 -> all outputs 0 immediately; no done pulse afterwards; next start completes normally.
- SIGNED_MULDIV_EN defined, op=11:
  - opa=0xFFF9 (-7), opb=2 -> lo=0xFFFD, hi=0xFFFF.
  - op=10, opa=0xFFFA (-6), opb=7 -> {hi,lo}=0xFFFFFFD6.
- SIGNED_MULDIV_EN undefined: op=10 with the same multiply operands -> unsigned product 0x0006FFD6.
